// File: rtl/sine_period_meter.sv
// Rising-midpoint-crossing period meter for offset-binary sine samples, with lock and loss-of-signal detect.
// Latency: period_out/period_valid/locked register 1 cycle after the crossing sample; timeout 1 cycle after the expiring sample.
// Backpressure: none; input is qualified by sample_valid only, and gaps in valid freeze all measurement state.
module sine_period_meter #(
  parameter int DW       = 16,
  parameter int MIDPOINT = 32768,
  parameter int HYST     = 1024,
  parameter int PW       = 16,
  parameter int LOCK_CNT = 4,
  parameter int TOL      = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sample_valid,
  input  logic [DW-1:0] sample_in,
  output logic [PW-1:0] period_out,
  output logic          period_valid,
  output logic          locked,
  output logic          timeout
);

  localparam int MW = $clog2(LOCK_CNT + 1);

  // Thresholds are one bit wider than the sample so MIDPOINT+HYST cannot wrap.
  localparam logic [DW:0]   LO_TH     = (DW+1)'(MIDPOINT - HYST);
  localparam logic [DW:0]   HI_TH     = (DW+1)'(MIDPOINT + HYST);
  localparam logic [PW:0]   TOL_W     = (PW+1)'(TOL);
  localparam logic [MW-1:0] MATCH_MAX = MW'(LOCK_CNT);
  // Largest count that may still be held; one more non-crossing sample is loss of signal.
  localparam logic [PW-1:0] CNT_LAST  = {{(PW-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    ACQ  = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          armed_q, armed_d;
  logic          skip_q, skip_d;          // next report is the first after arming: no match check
  logic [PW-1:0] cnt_q, cnt_d;
  logic [MW-1:0] match_cnt_q, match_cnt_d;
  logic [PW-1:0] prev_period_q, prev_period_d;
  logic [PW-1:0] period_out_q, period_out_d;
  logic          period_valid_q, period_valid_d;
  logic          locked_q, locked_d;
  logic          timeout_q, timeout_d;

  logic [DW:0]   samp_w;
  logic          is_lo;
  logic          is_hi;
  logic          rising;
  logic [PW-1:0] period_new;
  logic [PW:0]   delta;
  logic          match;
  logic [MW-1:0] match_inc;

  assign samp_w     = {1'b0, sample_in};
  assign is_lo      = (samp_w <= LO_TH);
  assign is_hi      = (samp_w >= HI_TH);
  assign rising     = (state_q == LOW) && is_hi;
  assign period_new = cnt_q + PW'(1);
  assign delta      = (period_new >= prev_period_q) ?
                      ({1'b0, period_new} - {1'b0, prev_period_q}) :
                      ({1'b0, prev_period_q} - {1'b0, period_new});
  assign match      = (delta <= TOL_W);
  assign match_inc  = (match_cnt_q == MATCH_MAX) ? MATCH_MAX : (match_cnt_q + MW'(1));

  // Next-state: hysteresis tracking, period counting, match/lock bookkeeping and loss-of-signal.
  always_comb begin
    state_d        = state_q;
    armed_d        = armed_q;
    skip_d         = skip_q;
    cnt_d          = cnt_q;
    match_cnt_d    = match_cnt_q;
    prev_period_d  = prev_period_q;
    period_out_d   = period_out_q;
    period_valid_d = 1'b0;
    locked_d       = locked_q;
    timeout_d      = 1'b0;

    if (sample_valid) begin
      case (state_q)
        ACQ:     if (is_lo) state_d = LOW;
        LOW:     if (is_hi) state_d = HIGH;
        HIGH:    if (is_lo) state_d = LOW;
        default: state_d = ACQ;
      endcase

      if (rising) begin
        // A crossing always wins over an expiring count.
        cnt_d = '0;
        if (!armed_q) begin
          armed_d = 1'b1;
          skip_d  = 1'b1;
        end else begin
          period_out_d   = period_new;
          period_valid_d = 1'b1;
          prev_period_d  = period_new;
          skip_d         = 1'b0;
          if (!skip_q) begin
            if (match) begin
              match_cnt_d = match_inc;
              locked_d    = (match_inc == MATCH_MAX);
            end else begin
              match_cnt_d = '0;
              locked_d    = 1'b0;
            end
          end
        end
      end else if (cnt_q == CNT_LAST) begin
        // No crossing within the measurable range: drop back to acquisition.
        timeout_d   = 1'b1;
        state_d     = ACQ;
        armed_d     = 1'b0;
        locked_d    = 1'b0;
        match_cnt_d = '0;
        cnt_d       = '0;
      end else begin
        cnt_d = cnt_q + PW'(1);
      end
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ACQ;
      armed_q        <= 1'b0;
      skip_q         <= 1'b0;
      cnt_q          <= '0;
      match_cnt_q    <= '0;
      prev_period_q  <= '0;
      period_out_q   <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      armed_q        <= armed_d;
      skip_q         <= skip_d;
      cnt_q          <= cnt_d;
      match_cnt_q    <= match_cnt_d;
      prev_period_q  <= prev_period_d;
      period_out_q   <= period_out_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      timeout_q      <= timeout_d;
    end
  end

  assign period_out   = period_out_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_sine_period_meter.sv
// Bench for sine_period_meter: a 16-bit and an 8-bit period instance run in lockstep against a reference model.
// Latency: outputs compared on the falling edge after each driven sample.
// Backpressure: none; sample_valid gaps are exercised directly.
module tb_sine_period_meter;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_valid;
  logic [15:0] sample_in;

  logic [15:0] p16;
  logic        pv16, lk16, to16;
  logic [7:0]  p8;
  logic        pv8, lk8, to8;

  always #5 clk = ~clk;

  sine_period_meter #(.PW(16)) dut16 (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_in(sample_in),
    .period_out(p16), .period_valid(pv16), .locked(lk16), .timeout(to16)
  );

  sine_period_meter #(.PW(8)) dut8 (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_in(sample_in),
    .period_out(p8), .period_valid(pv8), .locked(lk8), .timeout(to8)
  );

  int checks   = 0;
  int failures = 0;
  int n        = 0;   // samples driven
  int ph       = 0;   // sine phase
  int sine_tbl[256];

  // Reference model: hysteresis comparator, crossing index bookkeeping, period as index difference.
  localparam int HI_V = 32768 + 1024;
  localparam int LO_V = 32768 - 1024;
  localparam int LOCK = 4;
  localparam int TOLV = 1;

  int          m_maxp[2] = '{65535, 255};
  int          m_idx[2], m_ref[2], m_prev[2], m_match[2];
  bit          m_seen_low[2], m_armed[2], m_have_prev[2];
  logic [15:0] e_per[2];
  logic        e_pv[2], e_lk[2], e_to[2];

  function automatic logic [15:0] sine_val(input int p, input int phase);
    return 16'(sine_tbl[(phase * (256 / p)) % 256]);
  endfunction

  function automatic logic [18:0] act_vec(input int k);
    if (k == 0) return {pv16, to16, lk16, p16};
    return {pv8, to8, lk8, 8'h00, p8};
  endfunction

  function automatic logic [18:0] exp_vec(input int k);
    logic [15:0] pe;
    pe = e_per[k];
    if (k == 0) return {e_pv[0], e_to[0], e_lk[0], pe};
    return {e_pv[1], e_to[1], e_lk[1], 8'h00, pe[7:0]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_idx[k] = 0; m_ref[k] = 0; m_prev[k] = 0; m_match[k] = 0;
      m_seen_low[k] = 0; m_armed[k] = 0; m_have_prev[k] = 0;
      e_per[k] = '0; e_pv[k] = 0; e_lk[k] = 0; e_to[k] = 0;
    end
  endtask

  task automatic model_step(input logic v, input logic [15:0] s);
    bit rising;
    int p, dd;
    for (int k = 0; k < 2; k++) begin
      e_pv[k] = 0;
      e_to[k] = 0;
      if (v) begin
        m_idx[k]++;
        rising = m_seen_low[k] && (int'(s) >= HI_V);
        if (rising) begin
          p = m_idx[k] - m_ref[k];
          if (m_armed[k]) begin
            e_pv[k]  = 1;
            e_per[k] = 16'(p);
            if (m_have_prev[k]) begin
              dd = p - m_prev[k];
              if (dd < 0) dd = -dd;
              if (dd <= TOLV) begin
                if (m_match[k] < LOCK) m_match[k]++;
                e_lk[k] = (m_match[k] == LOCK);
              end else begin
                m_match[k] = 0;
                e_lk[k]    = 0;
              end
            end
            m_prev[k]      = p;
            m_have_prev[k] = 1;
          end else begin
            m_armed[k]     = 1;
            m_have_prev[k] = 0;
          end
          m_ref[k]      = m_idx[k];
          m_seen_low[k] = 0;
        end else if (m_idx[k] - m_ref[k] == m_maxp[k]) begin
          e_to[k]       = 1;
          m_seen_low[k] = 0;
          m_armed[k]    = 0;
          e_lk[k]       = 0;
          m_match[k]    = 0;
          m_ref[k]      = m_idx[k];
        end else if (int'(s) <= LO_V) begin
          m_seen_low[k] = 1;
        end else if (int'(s) >= HI_V) begin
          m_seen_low[k] = 0;
        end
      end
    end
  endtask

  // Drive one cycle from a falling edge, advance the model, return at the next falling edge.
  task automatic step(input logic v, input logic [15:0] s);
    sample_valid = v;
    sample_in    = s;
    @(posedge clk);
    model_step(v, s);
    @(negedge clk);
    n++;
  endtask

  task automatic do_reset();
    sample_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; sample_valid = 1'b0; sample_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act_vec(k) !== 19'd0) begin
        failures++; $display("FAIL reset_idle pw%0d got=%h exp=0", k ? 8 : 16, act_vec(k));
      end
    end
    sample_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample_in = (i % 2 == 1) ? 16'h0000 : 16'hFFFF;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_vec(k) !== 19'd0) begin
          failures++; $display("FAIL reset_held pw%0d got=%h exp=0", k ? 8 : 16, act_vec(k));
        end
      end
    end
    sample_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_nco_lock();
    int rpt, last;
    logic exp_l;
    rpt = 0; last = 0;
    do_reset(); ph = 0;
    for (int i = 0; i < 10 * 256; i++) begin
      step(1'b1, sine_val(256, ph)); ph++;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_vec(k) !== exp_vec(k)) begin
          failures++; $display("FAIL nco_lockstep pw%0d n=%0d got=%h exp=%h", k ? 8 : 16, n, act_vec(k), exp_vec(k));
        end
      end
      if (pv16) begin
        rpt++;
        checks++;
        if (p16 !== 16'd256) begin failures++; $display("FAIL nco_period got=%0d exp=256", p16); end
        if (rpt > 1) begin
          checks++;
          if (i - last != 256) begin failures++; $display("FAIL nco_spacing got=%0d exp=256", i - last); end
        end
        if (rpt == 4 || rpt == 5) begin
          exp_l = (rpt == 5);
          checks++;
          if (lk16 !== exp_l) begin failures++; $display("FAIL nco_lock rpt=%0d got=%b exp=%b", rpt, lk16, exp_l); end
        end
        last = i;
      end
    end
    checks++;
    if (rpt != 8) begin failures++; $display("FAIL nco_reports got=%0d exp=8", rpt); end
  endtask

  task automatic test_valid_toggle();
    int rpt, last;
    logic exp_l;
    rpt = 0; last = 0;
    do_reset(); ph = 0;
    for (int i = 0; i < 8 * 512; i++) begin
      if (i % 2 == 0) begin
        step(1'b1, sine_val(256, ph)); ph++;
      end else begin
        step(1'b0, 16'($urandom));
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_vec(k) !== exp_vec(k)) begin
          failures++; $display("FAIL toggle_lockstep pw%0d n=%0d got=%h exp=%h", k ? 8 : 16, n, act_vec(k), exp_vec(k));
        end
      end
      if (pv16) begin
        rpt++;
        checks++;
        if (p16 !== 16'd256) begin failures++; $display("FAIL toggle_period got=%0d exp=256", p16); end
        if (rpt > 1) begin
          checks++;
          if (i - last != 512) begin failures++; $display("FAIL toggle_spacing got=%0d exp=512", i - last); end
        end
        if (rpt == 4 || rpt == 5) begin
          exp_l = (rpt == 5);
          checks++;
          if (lk16 !== exp_l) begin failures++; $display("FAIL toggle_lock rpt=%0d got=%b exp=%b", rpt, lk16, exp_l); end
        end
        last = i;
      end
    end
    checks++;
    if (rpt != 6) begin failures++; $display("FAIL toggle_reports got=%0d exp=6", rpt); end
  endtask

  task automatic test_dither();
    int drpt, rpt;
    logic [15:0] last_p;
    drpt = 0; rpt = 0; last_p = '0;
    for (int i = 0; i < 1000; i++) begin
      step(1'b1, 16'(32768 + int'($urandom_range(1600, 0)) - 800));
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_vec(k) !== exp_vec(k)) begin
          failures++; $display("FAIL dither_lockstep pw%0d n=%0d got=%h exp=%h", k ? 8 : 16, n, act_vec(k), exp_vec(k));
        end
      end
      if (pv16) drpt++;
    end
    checks++;
    if (drpt != 0) begin failures++; $display("FAIL dither_quiet got=%0d exp=0", drpt); end
    ph = 0;
    for (int i = 0; i < 6 * 256; i++) begin
      step(1'b1, sine_val(256, ph)); ph++;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_vec(k) !== exp_vec(k)) begin
          failures++; $display("FAIL dither_lockstep pw%0d n=%0d got=%h exp=%h", k ? 8 : 16, n, act_vec(k), exp_vec(k));
        end
      end
      if (pv16) begin rpt++; last_p = p16; end
    end
    checks++;
    if (rpt != 6) begin failures++; $display("FAIL dither_reports got=%0d exp=6", rpt); end
    checks++;
    if (last_p !== 16'd256) begin failures++; $display("FAIL dither_period got=%0d exp=256", last_p); end
    checks++;
    if (lk16 !== 1'b1) begin failures++; $display("FAIL dither_relock got=%b exp=1", lk16); end
  endtask

  task automatic test_switch();
    int d, post;
    logic exp_l;
    post = 0;
    do_reset(); ph = 0;
    for (int i = 0; i < 7 * 256; i++) begin
      step(1'b1, sine_val(256, ph)); ph++;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_vec(k) !== exp_vec(k)) begin
          failures++; $display("FAIL switch_lockstep pw%0d n=%0d got=%h exp=%h", k ? 8 : 16, n, act_vec(k), exp_vec(k));
        end
      end
    end
    checks++;
    if (lk16 !== 1'b1) begin failures++; $display("FAIL switch_prelock got=%b exp=1", lk16); end
    d = int'($urandom_range(100, 12));
    for (int i = 0; i < d; i++) begin
      step(1'b1, sine_val(256, ph)); ph++;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_vec(k) !== exp_vec(k)) begin
          failures++; $display("FAIL switch_lockstep pw%0d n=%0d got=%h exp=%h", k ? 8 : 16, n, act_vec(k), exp_vec(k));
        end
      end
    end
    for (int i = 0; i < 10 * 128; i++) begin
      step(1'b1, sine_val(128, i));
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_vec(k) !== exp_vec(k)) begin
          failures++; $display("FAIL switch_lockstep pw%0d n=%0d got=%h exp=%h", k ? 8 : 16, n, act_vec(k), exp_vec(k));
        end
      end
      if (pv16) begin
        post++;
        if (post == 1) begin
          checks++;
          if (p16 !== 16'(d + 127)) begin failures++; $display("FAIL switch_transition got=%0d exp=%0d", p16, d + 127); end
          checks++;
          if (lk16 !== 1'b0) begin failures++; $display("FAIL switch_unlock got=%b exp=0", lk16); end
        end else begin
          checks++;
          if (p16 !== 16'd128) begin failures++; $display("FAIL switch_period post=%0d got=%0d exp=128", post, p16); end
          exp_l = (post >= 6);
          checks++;
          if (lk16 !== exp_l) begin failures++; $display("FAIL switch_relock post=%0d got=%b exp=%b", post, lk16, exp_l); end
        end
      end
    end
    checks++;
    if (post != 9) begin failures++; $display("FAIL switch_reports got=%0d exp=9", post); end
  endtask

  task automatic test_timeout();
    int last8, to_n, to8_cnt, to16_cnt;
    last8 = 0; to_n = 0; to8_cnt = 0; to16_cnt = 0;
    do_reset();
    for (int i = 0; i < 8 * 128; i++) begin
      step(1'b1, sine_val(128, i));
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_vec(k) !== exp_vec(k)) begin
          failures++; $display("FAIL timeout_lockstep pw%0d n=%0d got=%h exp=%h", k ? 8 : 16, n, act_vec(k), exp_vec(k));
        end
      end
      if (pv8) last8 = n;
    end
    checks++;
    if (lk8 !== 1'b1) begin failures++; $display("FAIL timeout_prelock8 got=%b exp=1", lk8); end
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 16'h0000);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_vec(k) !== exp_vec(k)) begin
          failures++; $display("FAIL timeout_lockstep pw%0d n=%0d got=%h exp=%h", k ? 8 : 16, n, act_vec(k), exp_vec(k));
        end
      end
      if (to8) begin to8_cnt++; to_n = n; end
      if (to16) to16_cnt++;
    end
    checks++;
    if (to8_cnt != 1) begin failures++; $display("FAIL timeout_once got=%0d exp=1", to8_cnt); end
    checks++;
    if (to_n - last8 != 255) begin failures++; $display("FAIL timeout_delay got=%0d exp=255", to_n - last8); end
    checks++;
    if (lk8 !== 1'b0) begin failures++; $display("FAIL timeout_unlock got=%b exp=0", lk8); end
    checks++;
    if (p8 !== 8'd128) begin failures++; $display("FAIL timeout_hold got=%0d exp=128", p8); end
    checks++;
    if (to16_cnt != 0) begin failures++; $display("FAIL timeout_wide got=%0d exp=0", to16_cnt); end
    checks++;
    if (lk16 !== 1'b1) begin failures++; $display("FAIL timeout_wide_lock got=%b exp=1", lk16); end
  endtask

  task automatic test_reset_mid();
    int rpt;
    rpt = 0;
    do_reset(); ph = 0;
    for (int i = 0; i < 7 * 256 + 60; i++) begin
      step(1'b1, sine_val(256, ph)); ph++;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_vec(k) !== exp_vec(k)) begin
          failures++; $display("FAIL rstmid_lockstep pw%0d n=%0d got=%h exp=%h", k ? 8 : 16, n, act_vec(k), exp_vec(k));
        end
      end
    end
    checks++;
    if ({lk16, p16} !== {1'b1, 16'd256}) begin failures++; $display("FAIL rstmid_pre got=%b/%0d exp=1/256", lk16, p16); end
    #2;
    rst = 1'b1;
    sample_valid = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act_vec(k) !== 19'd0) begin
        failures++; $display("FAIL rstmid_async pw%0d got=%h exp=0", k ? 8 : 16, act_vec(k));
      end
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 700; i++) begin
      step(1'b1, sine_val(256, ph)); ph++;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_vec(k) !== exp_vec(k)) begin
          failures++; $display("FAIL rstmid_lockstep pw%0d n=%0d got=%h exp=%h", k ? 8 : 16, n, act_vec(k), exp_vec(k));
        end
      end
      if (pv16) begin
        rpt++;
        if (rpt == 1) begin
          checks++;
          if (p16 !== 16'd256) begin failures++; $display("FAIL rstmid_period got=%0d exp=256", p16); end
          checks++;
          if (i != 454) begin failures++; $display("FAIL rstmid_first got=%0d exp=454", i); end
        end
      end
    end
    checks++;
    if (rpt != 1) begin failures++; $display("FAIL rstmid_reports got=%0d exp=1", rpt); end
  endtask

  initial begin
    for (int k = 0; k < 256; k++)
      sine_tbl[k] = 32768 + $rtoi($floor(32767.0 * $sin(6.283185307179586 * k / 256.0) + 0.5));
    test_reset();
    test_nco_lock();
    test_valid_toggle();
    test_dither();
    test_switch();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
